cmlk_exposure_sequencer: RTL and testbench

Frame-trigger sequencer for the Camera Link imaging controller. It takes the exposure configuration held in the AXI4-Lite register bank (period, delay, exposure width, frame count) and generates the CC1 camera trigger waveform. It supports free-running and externally triggered modes, and reports run status back to the register bank. It sits between the register bank outputs and the Camera Link CC pins.

---
 rtl/cmlk_exposure_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cmlk_exposure_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cmlk_exposure_sequencer.sv
// Camera Link CC1 frame-trigger sequencer: free-running or externally triggered exposure runs
// driven by latched period/delay/exposure/frame-count settings.
module cmlk_exposure_sequencer #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned FRM_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_exposure,
  input  logic [FRM_WIDTH-1:0] cfg_frames,
  input  logic                 cfg_ext_mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 ext_trig,
  output logic                 cc_trig,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FRM_WIDTH-1:0] frames_done,
  output logic                 cfg_err,
  output logic                 trig_overrun
);

  typedef enum logic [1:0] {StIdle, StArm, StFrame} state_e;

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] delay_q, delay_d;
  logic [CNT_WIDTH-1:0] exposure_q, exposure_d;
  logic [FRM_WIDTH-1:0] frames_q, frames_d;
  logic                 ext_mode_q, ext_mode_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [FRM_WIDTH-1:0] frames_done_q, frames_done_d;
  logic                 overrun_q, overrun_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cc_trig_q, cc_trig_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ext_prev_q;

  logic                 cfg_valid;
  logic                 accept;
  logic                 ext_edge;
  logic                 last_cycle;
  logic                 run_complete;
  logic [CNT_WIDTH:0]   win_end_d;

  // Sum formed one bit wider so delay+exposure cannot wrap past the period check.
  assign cfg_valid = (cfg_exposure != '0) &&
                     (({1'b0, cfg_delay} + {1'b0, cfg_exposure}) <= {1'b0, cfg_period});
  assign accept     = (state_q == StIdle) && start && cfg_valid;
  assign ext_edge   = ext_trig && !ext_prev_q;
  assign last_cycle = (state_q == StFrame) && (pcnt_q == period_q - CNT_WIDTH'(1));
  assign run_complete = (frames_q != '0) &&
                        (({1'b0, frames_done_q} + (FRM_WIDTH + 1)'(1)) == {1'b0, frames_q});

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = cfg_ext_mode ? StArm : StFrame;
        end
      end
      StArm: begin
        if (stop) begin
          state_d = StIdle;
        end else if (ext_edge) begin
          state_d = StFrame;
        end
      end
      StFrame: begin
        if (last_cycle) begin
          if (stop_pend_q || stop || run_complete) begin
            state_d = StIdle;
          end else begin
            state_d = ext_mode_q ? StArm : StFrame;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: shadow config, phase counter, run bookkeeping
  always_comb begin
    period_d      = period_q;
    delay_d       = delay_q;
    exposure_d    = exposure_q;
    frames_d      = frames_q;
    ext_mode_d    = ext_mode_q;
    frames_done_d = frames_done_q;
    overrun_d     = overrun_q;
    pcnt_d        = '0;
    stop_pend_d   = 1'b0;

    if (accept) begin
      period_d      = cfg_period;
      delay_d       = cfg_delay;
      exposure_d    = cfg_exposure;
      frames_d      = cfg_frames;
      ext_mode_d    = cfg_ext_mode;
      frames_done_d = '0;
      overrun_d     = 1'b0;
    end

    if (state_q == StFrame) begin
      if (ext_edge) begin
        overrun_d = 1'b1;
      end
      if (last_cycle) begin
        if (frames_done_q != '1) begin
          frames_done_d = frames_done_q + FRM_WIDTH'(1);
        end
      end else begin
        pcnt_d      = pcnt_q + CNT_WIDTH'(1);
        stop_pend_d = stop_pend_q || stop;
      end
    end
  end

  // Output logic: registered outputs are computed from the upcoming state and phase
  always_comb begin
    busy      = (state_q != StIdle);
    win_end_d = {1'b0, delay_d} + {1'b0, exposure_d};
    cfg_err_d = (state_q == StIdle) && start && !cfg_valid;
    cc_trig_d = (state_d == StFrame) && (pcnt_d >= delay_d) && ({1'b0, pcnt_d} < win_end_d);
    frame_done_d = (state_d == StFrame) && (pcnt_d == period_d - CNT_WIDTH'(1));

    cc_trig      = cc_trig_q;
    frame_done   = frame_done_q;
    frames_done  = frames_done_q;
    cfg_err      = cfg_err_q;
    trig_overrun = overrun_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pcnt_q        <= '0;
      period_q      <= '0;
      delay_q       <= '0;
      exposure_q    <= '0;
      frames_q      <= '0;
      ext_mode_q    <= 1'b0;
      stop_pend_q   <= 1'b0;
      frames_done_q <= '0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      cc_trig_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      ext_prev_q    <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      period_q      <= period_d;
      delay_q       <= delay_d;
      exposure_q    <= exposure_d;
      frames_q      <= frames_d;
      ext_mode_q    <= ext_mode_d;
      stop_pend_q   <= stop_pend_d;
      frames_done_q <= frames_done_d;
      overrun_q     <= overrun_d;
      cfg_err_q     <= cfg_err_d;
      cc_trig_q     <= cc_trig_d;
      frame_done_q  <= frame_done_d;
      ext_prev_q    <= ext_trig;
    end
  end

endmodule

// File: tb/tb_cmlk_exposure_sequencer.sv
// Directed bench for cmlk_exposure_sequencer; expected waveforms are hand-derived cycle tables.
module tb_cmlk_exposure_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_delay = '0;
  logic [31:0] cfg_exposure = '0;
  logic [15:0] cfg_frames = '0;
  logic        cfg_ext_mode = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ext_trig = 1'b0;
  logic        cc_trig;
  logic        busy;
  logic        frame_done;
  logic [15:0] frames_done;
  logic        cfg_err;
  logic        trig_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  cmlk_exposure_sequencer #(
    .CNT_WIDTH(32),
    .FRM_WIDTH(16)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_period  (cfg_period),
    .cfg_delay   (cfg_delay),
    .cfg_exposure(cfg_exposure),
    .cfg_frames  (cfg_frames),
    .cfg_ext_mode(cfg_ext_mode),
    .start       (start),
    .stop        (stop),
    .ext_trig    (ext_trig),
    .cc_trig     (cc_trig),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_done (frames_done),
    .cfg_err     (cfg_err),
    .trig_overrun(trig_overrun)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cfg(input int per, input int dly, input int expo, input int frm,
                         input logic ext);
    cfg_period   = per;
    cfg_delay    = dly;
    cfg_exposure = expo;
    cfg_frames   = 16'(frm);
    cfg_ext_mode = ext;
  endtask

  // After return the bench sits in cycle t+1 of a start sampled in cycle t.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_cc_trig", 32'(cc_trig), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frames_done", 32'(frames_done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_overrun", 32'(trig_overrun), 0);
    ARESETN = 1'b1;
    tick();

    // Free-run: period 10, delay 2, exposure 3, three frames
    set_cfg(10, 2, 3, 3, 1'b0);
    pulse_start();
    for (int k = 1; k <= 31; k++) begin
      check($sformatf("fr_cc_k%0d", k), 32'(cc_trig),
            32'((k % 10 >= 3) && (k % 10 <= 5) && (k <= 30)));
      check($sformatf("fr_fd_k%0d", k), 32'(frame_done), 32'(k == 10 || k == 20 || k == 30));
      check($sformatf("fr_busy_k%0d", k), 32'(busy), 32'(k <= 30));
      tick();
    end
    #0;
    // Now in cycle t+32; frames_done holds its final value
    check("fr_frames_done", 32'(frames_done), 3);

    // Invalid: exposure 0
    set_cfg(10, 2, 0, 1, 1'b0);
    pulse_start();
    check("inv0_cfg_err", 32'(cfg_err), 1);
    check("inv0_busy", 32'(busy), 0);
    tick();
    check("inv0_cfg_err_clr", 32'(cfg_err), 0);
    check("inv0_busy2", 32'(busy), 0);

    // Invalid: delay+exposure exceeds period
    set_cfg(10, 8, 3, 1, 1'b0);
    pulse_start();
    check("inv1_cfg_err", 32'(cfg_err), 1);
    check("inv1_busy", 32'(busy), 0);
    tick();
    check("inv1_busy2", 32'(busy), 0);

    // Ext mode: period 6, delay 0, exposure 2, two frames
    set_cfg(6, 0, 2, 2, 1'b1);
    pulse_start();
    check("ext_arm_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ext_arm_cc%0d", k), 32'(cc_trig), 0);
      tick();
    end
    ext_trig = 1'b1;
    tick();                                        // e+1
    ext_trig = 1'b0;
    check("ext_cc_e1", 32'(cc_trig), 1);
    tick();                                        // e+2
    check("ext_cc_e2", 32'(cc_trig), 1);
    tick();                                        // e+3
    check("ext_cc_e3", 32'(cc_trig), 0);
    check("ext_ovr_before", 32'(trig_overrun), 0);
    ext_trig = 1'b1;
    tick();                                        // e+4
    ext_trig = 1'b0;
    check("ext_ovr_set", 32'(trig_overrun), 1);
    tick();
    tick();                                        // e+6
    check("ext_fd1", 32'(frame_done), 1);
    tick();                                        // e+7, back in ARM
    check("ext_arm2_busy", 32'(busy), 1);
    check("ext_arm2_cc", 32'(cc_trig), 0);
    check("ext_frames1", 32'(frames_done), 1);
    ext_trig = 1'b1;
    tick();                                        // e+8, frame 2 pcnt 0
    ext_trig = 1'b0;
    check("ext_f2_cc", 32'(cc_trig), 1);
    for (int k = 9; k <= 14; k++) begin
      tick();
      check($sformatf("ext_f2_fd_e%0d", k), 32'(frame_done), 32'(k == 13));
      check($sformatf("ext_f2_busy_e%0d", k), 32'(busy), 32'(k <= 13));
    end
    check("ext_frames2", 32'(frames_done), 2);
    check("ext_ovr_sticky", 32'(trig_overrun), 1);

    // Continuous run stopped mid-exposure
    set_cfg(10, 2, 5, 0, 1'b0);
    pulse_start();
    check("stp_ovr_clr", 32'(trig_overrun), 0);
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("stp_cc_k%0d", k), 32'(cc_trig), 32'(k >= 3 && k <= 7));
      check($sformatf("stp_fd_k%0d", k), 32'(frame_done), 32'(k == 10));
      check($sformatf("stp_busy_k%0d", k), 32'(busy), 32'(k <= 10));
      stop = (k == 4);
      tick();
      stop = 1'b0;
    end

    // Period changed mid-run must not take effect
    set_cfg(10, 2, 3, 2, 1'b0);
    pulse_start();
    for (int k = 1; k <= 21; k++) begin
      check($sformatf("pc_fd_k%0d", k), 32'(frame_done), 32'(k == 10 || k == 20));
      check($sformatf("pc_busy_k%0d", k), 32'(busy), 32'(k <= 20));
      if (k == 2) cfg_period = 4;
      tick();
    end
    set_cfg(4, 1, 1, 1, 1'b0);
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("pc2_cc_k%0d", k), 32'(cc_trig), 32'(k == 2));
      check($sformatf("pc2_fd_k%0d", k), 32'(frame_done), 32'(k == 4));
      check($sformatf("pc2_busy_k%0d", k), 32'(busy), 32'(k <= 4));
      tick();
    end

    // Asynchronous reset during exposure of frame 2
    set_cfg(10, 2, 3, 0, 1'b0);
    pulse_start();
    repeat (12) tick();                            // k=13
    check("ar_pre_cc", 32'(cc_trig), 1);
    check("ar_pre_frames", 32'(frames_done), 1);
    #2 ARESETN = 1'b0;
    #1;
    check("ar_cc", 32'(cc_trig), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_frames", 32'(frames_done), 0);
    #2 ARESETN = 1'b1;
    tick();
    check("ar_idle_busy", 32'(busy), 0);
    set_cfg(10, 2, 3, 1, 1'b0);
    pulse_start();
    for (int k = 1; k <= 11; k++) begin
      check($sformatf("ar_cc_k%0d", k), 32'(cc_trig), 32'(k >= 3 && k <= 5));
      check($sformatf("ar_fd_k%0d", k), 32'(frame_done), 32'(k == 10));
      check($sformatf("ar_busy_k%0d", k), 32'(busy), 32'(k <= 10));
      tick();
    end
    check("ar_frames_final", 32'(frames_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
